bcd_to_binary_seq: RTL and testbench

BCD_TO_BINARY_SEQ -- requirements
Module: bcd_to_binary_seq

---
 rtl/bcd_to_binary_seq.sv | 127 ++++++++++++
 tb/tb_bcd_to_binary_seq.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary_seq.sv
// ============================================================================
// Module   : bcd_to_binary_seq
// Purpose  : Sequential 3-digit BCD (000-255) to 8-bit binary converter using
//            reverse double-dabble, one shift per clock.
// Options  : BCD_SATURATE_EN - over-range input saturates to 8'hFF, err=0
//            (default build: over-range gives bin=0, err=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_binary_seq (
    input  logic       CLOCK_50,
    input  logic       RST_N,
    input  logic       start,
    input  logic [1:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [7:0] bin,
    output logic       done,
    output logic       busy,
    output logic       err
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SHIFT  = 2'd1;
    localparam logic [1:0] c_FINISH = 2'd2;

    localparam logic [2:0] c_LAST_SHIFT = 3'd7;

    logic [1:0]  r_state;
    logic [2:0]  r_cnt;
    logic [17:0] r_sreg;
    logic        r_bad_digit;
    logic        r_over_range;
    logic [7:0]  r_bin;
    logic        r_err;
    logic        r_done;

    logic        w_accept;
    logic        w_bad_digit;
    logic [9:0]  w_value;
    logic        w_over_range;
    logic [17:0] w_shifted;
    logic [3:0]  w_tens_adj;
    logic [3:0]  w_ones_adj;
    logic [17:0] w_sreg_next;
    logic [7:0]  w_fin_bin;
    logic        w_fin_err;

    assign w_accept     = (r_state == c_IDLE) && start;
    assign w_bad_digit  = (tens > 4'd9) || (ones > 4'd9);
    assign w_value      = 10'(hundreds) * 10'd100 + 10'(tens) * 10'd10 + 10'(ones);
    assign w_over_range = !w_bad_digit && (w_value > 10'd255);

    // Shift right, then pull each BCD digit back from "half of 10" (>=8) by 3.
    assign w_shifted   = {1'b0, r_sreg[17:1]};
    assign w_tens_adj  = (w_shifted[15:12] >= 4'd8) ? (w_shifted[15:12] - 4'd3) : w_shifted[15:12];
    assign w_ones_adj  = (w_shifted[11:8]  >= 4'd8) ? (w_shifted[11:8]  - 4'd3) : w_shifted[11:8];
    assign w_sreg_next = {w_shifted[17:16], w_tens_adj, w_ones_adj, w_shifted[7:0]};

    always_comb begin
        w_fin_bin = r_sreg[7:0];
        w_fin_err = 1'b0;
        if (r_bad_digit) begin
            w_fin_bin = 8'h00;
            w_fin_err = 1'b1;
        end else if (r_over_range) begin
`ifdef BCD_SATURATE_EN
            w_fin_bin = 8'hFF;
            w_fin_err = 1'b0;
`else
            w_fin_bin = 8'h00;
            w_fin_err = 1'b1;
`endif
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= c_IDLE;
            r_cnt        <= 3'd0;
            r_sreg       <= 18'd0;
            r_bad_digit  <= 1'b0;
            r_over_range <= 1'b0;
            r_bin        <= 8'h00;
            r_err        <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= (r_state == c_FINISH);
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_sreg       <= {hundreds, tens, ones, 8'h00};
                        r_cnt        <= 3'd0;
                        r_bad_digit  <= w_bad_digit;
                        r_over_range <= w_over_range;
                        // Unconvertible requests skip straight to reporting.
                        r_state      <= (w_bad_digit || w_over_range) ? c_FINISH : c_SHIFT;
                    end
                end
                c_SHIFT: begin
                    r_sreg <= w_sreg_next;
                    r_cnt  <= r_cnt + 3'd1;
                    if (r_cnt == c_LAST_SHIFT) begin
                        r_state <= c_FINISH;
                    end
                end
                c_FINISH: begin
                    r_bin   <= w_fin_bin;
                    r_err   <= w_fin_err;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bin  = r_bin;
    assign err  = r_err;
    assign done = r_done;
    assign busy = (r_state != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_binary_seq.sv
// ============================================================================
// Module   : tb_bcd_to_binary_seq
// Purpose  : Self-checking bench for bcd_to_binary_seq against an arithmetic
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_to_binary_seq;

    logic       CLOCK_50 = 1'b0;
    logic       RST_N    = 1'b1;
    logic       start    = 1'b0;
    logic [1:0] hundreds = 2'd0;
    logic [3:0] tens     = 4'd0;
    logic [3:0] ones     = 4'd0;
    logic [7:0] bin;
    logic       done;
    logic       busy;
    logic       err;

    int n_vec = 0;
    int n_err = 0;

    bcd_to_binary_seq dut (
        .CLOCK_50 (CLOCK_50),
        .RST_N    (RST_N),
        .start    (start),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones),
        .bin      (bin),
        .done     (done),
        .busy     (busy),
        .err      (err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Expected result straight from the decimal value of the digits.
    function automatic void model(input int h, input int t, input int o,
                                  output logic [7:0] eb, output logic ee, output int el);
        int v;
        v = 100 * h + 10 * t + o;
        if (t > 9 || o > 9) begin
            eb = 8'h00; ee = 1'b1; el = 1;
        end else if (v > 255) begin
`ifdef BCD_SATURATE_EN
            eb = 8'hFF; ee = 1'b0;
`else
            eb = 8'h00; ee = 1'b1;
`endif
            el = 1;
        end else begin
            eb = 8'(v); ee = 1'b0; el = 9;
        end
    endfunction

    // Issue one start pulse and report edges-to-done (-1 on timeout).
    task automatic run_conv(input int h, input int t, input int o,
                            output int lat, output logic [7:0] b, output logic e, output logic bz);
        int hv, tv, ov;
        hv = h; tv = t; ov = o;
        @(negedge CLOCK_50);
        start = 1'b1; hundreds = hv[1:0]; tens = tv[3:0]; ones = ov[3:0];
        @(posedge CLOCK_50);
        #1;
        bz    = busy;
        start = 1'b0;
        lat   = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge CLOCK_50);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        b = bin;
        e = err;
    endtask

    task automatic test_reset();
        #2 RST_N = 1'b0;
        #1;
        n_vec++;
        if ({bin, done, busy, err} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got bin=%h done=%b busy=%b err=%b, want all zero", bin, done, busy, err);
        end
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        RST_N = 1'b1;
        @(posedge CLOCK_50);
        #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        int lat; logic [7:0] b; logic e, bz;
        int hs[3] = '{2, 1, 0};
        int ts[3] = '{5, 2, 0};
        int os[3] = '{5, 8, 0};
        logic [7:0] want[3] = '{8'hFF, 8'h80, 8'h00};
        for (int k = 0; k < 3; k++) begin
            run_conv(hs[k], ts[k], os[k], lat, b, e, bz);
            n_vec++;
            if (bz !== 1'b1 || lat != 9 || b !== want[k] || e !== 1'b0) begin
                n_err++;
                $display("FAIL directed_%0d: got busy=%b lat=%0d bin=%h err=%b, want 1 9 %h 0", k, bz, lat, b, e, want[k]);
            end
            @(posedge CLOCK_50);
            #1;
            n_vec++;
            if (done !== 1'b0) begin
                n_err++;
                $display("FAIL done_width_%0d: got done=%b one cycle later, want 0", k, done);
            end
        end
    endtask

    task automatic test_invalid_and_overrange();
        int lat, el; logic [7:0] b, eb; logic e, ee, bz;
        int hs[3] = '{0, 2, 3};
        int ts[3] = '{10, 5, 9};
        int os[3] = '{3, 6, 15};
        for (int k = 0; k < 3; k++) begin
            model(hs[k], ts[k], os[k], eb, ee, el);
            run_conv(hs[k], ts[k], os[k], lat, b, e, bz);
            n_vec++;
            if (lat != el || b !== eb || e !== ee) begin
                n_err++;
                $display("FAIL bypass_%0d: got lat=%0d bin=%h err=%b, want %0d %h %b", k, lat, b, e, el, eb, ee);
            end
        end
    endtask

    task automatic test_random();
        int lat, el, h, t, o; logic [7:0] b, eb; logic e, ee, bz;
        for (int k = 0; k < 40; k++) begin
            h = int'($urandom_range(0, 3));
            t = (k % 4 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
            o = (k % 5 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
            model(h, t, o, eb, ee, el);
            run_conv(h, t, o, lat, b, e, bz);
            n_vec++;
            if (lat != el || b !== eb || e !== ee) begin
                n_err++;
                $display("FAIL random_%0d(%0d%0d%0d): got lat=%0d bin=%h err=%b, want %0d %h %b",
                         k, h, t, o, lat, b, e, el, eb, ee);
            end
        end
    endtask

    task automatic test_back_to_back();
        int first, second, edge_n;
        int ts[2] = '{2, 10};
        int want_gap[2] = '{10, 2};
        logic [7:0] want_bin[2] = '{8'h80, 8'h00};
        logic want_err[2] = '{1'b0, 1'b1};
        for (int k = 0; k < 2; k++) begin
            int tv;
            tv = ts[k];
            @(negedge CLOCK_50);
            start = 1'b1; hundreds = 2'd1 - 2'(k); tens = tv[3:0]; ones = (k == 0) ? 4'd8 : 4'd3;
            first = -1; second = -1; edge_n = 0;
            while (edge_n < 40 && second < 0) begin
                @(posedge CLOCK_50);
                #1;
                edge_n++;
                if (done) begin
                    if (first < 0) first = edge_n;
                    else second = edge_n;
                end
            end
            n_vec++;
            if (second < 0 || second - first != want_gap[k] || bin !== want_bin[k] || err !== want_err[k]) begin
                n_err++;
                $display("FAIL back_to_back_%0d: got gap=%0d bin=%h err=%b, want %0d %h %b",
                         k, second - first, bin, err, want_gap[k], want_bin[k], want_err[k]);
            end
            @(negedge CLOCK_50);
            start = 1'b0;
            repeat (12) @(posedge CLOCK_50);
        end
    endtask

    task automatic test_busy_ignore();
        int lat, extra;
        @(negedge CLOCK_50);
        start = 1'b1; hundreds = 2'd1; tens = 4'd9; ones = 4'd9;
        @(posedge CLOCK_50);
        #1 start = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        start = 1'b1; hundreds = 2'd0; tens = 4'd4; ones = 4'd2;
        @(posedge CLOCK_50);
        #1 start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge CLOCK_50);
            #1;
            if (done) begin
                lat = 4 + i;
                break;
            end
        end
        n_vec++;
        if (lat != 9 || bin !== 8'd199 || err !== 1'b0) begin
            n_err++;
            $display("FAIL busy_ignore: got lat=%0d bin=%h err=%b, want 9 c7 0", lat, bin, err);
        end
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge CLOCK_50);
            #1;
            if (done || busy) extra++;
        end
        n_vec++;
        if (extra != 0) begin
            n_err++;
            $display("FAIL no_queue: got %0d cycles of busy/done after finish, want 0", extra);
        end
    endtask

    task automatic test_reset_abort();
        int lat, seen; logic [7:0] b; logic e, bz;
        @(negedge CLOCK_50);
        start = 1'b1; hundreds = 2'd1; tens = 4'd9; ones = 4'd9;
        @(posedge CLOCK_50);
        #1 start = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        start = 1'b1; hundreds = 2'd2; tens = 4'd0; ones = 4'd7;
        @(posedge CLOCK_50);
        #1 start = 1'b0;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        RST_N = 1'b0;
        #1;
        n_vec++;
        if ({bin, done, busy, err} !== 11'd0) begin
            n_err++;
            $display("FAIL abort_outputs: got bin=%h done=%b busy=%b err=%b, want all zero", bin, done, busy, err);
        end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLOCK_50);
            #1;
            if (done) seen++;
        end
        @(negedge CLOCK_50);
        RST_N = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLOCK_50);
            #1;
            if (done || busy) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL abort_no_done: got %0d done/busy cycles, want 0", seen);
        end
        run_conv(0, 4, 2, lat, b, e, bz);
        n_vec++;
        if (lat != 9 || b !== 8'h2A || e !== 1'b0) begin
            n_err++;
            $display("FAIL after_reset: got lat=%0d bin=%h err=%b, want 9 2a 0", lat, b, e);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_invalid_and_overrange();
        test_random();
        test_back_to_back();
        test_busy_ignore();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
